// File: rtl/prog_ctr_seq.sv
// Program-counter sequencer: latches the selected program, steps or jumps the
// instruction address, runs the start/done handshake and counts RUN cycles.
module prog_ctr_seq #(
    parameter logic [7:0]  START_P0 = 8'd0,
    parameter logic [7:0]  START_P1 = 8'd0,
    parameter logic [7:0]  START_P2 = 8'd0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Problem,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic [7:0]       Jump,
    output logic [7:0]       ProgCtr,
    output logic [1:0]       ProblemQ,
    output logic             Busy,
    output logic             Done,
    output logic             Fault,
    output logic [CNT_W-1:0] CycleCnt
);

    localparam int unsigned PC_W  = 8;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] PROB_ILLEGAL = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [SEL_W-1:0]   prob_q, prob_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    entry_pc;

    // Entry address for the requested program.
    always_comb begin
        entry_pc = START_P0;
        case (Problem)
            2'd0:    entry_pc = START_P0;
            2'd1:    entry_pc = START_P1;
            2'd2:    entry_pc = START_P2;
            default: entry_pc = START_P0;
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        prob_d  = prob_q;
        cnt_d   = cnt_q;
        fault_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    if (Problem == PROB_ILLEGAL) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        pc_d    = entry_pc;
                        prob_d  = Problem;
                        cnt_d   = '0;
                    end
                end
            end
            ST_RUN: begin
                // Every RUN edge counts, stalls and the halting edge included.
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (Stall) begin
                    pc_d = pc_q;
                end else if (Halt) begin
                    state_d = ST_DONE;
                end else if (BranchEn) begin
                    pc_d = Jump;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            prob_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prob_q  <= prob_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr  = pc_q;
    assign ProblemQ = prob_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Fault    = fault_q;
    assign CycleCnt = cnt_q;

endmodule
